// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter reset value and
// saturating increment/decrement on a width-agnostic counter container.
package bp_pkg;

    localparam int CTR_W_MAX = 8;

    typedef logic [CTR_W_MAX-1:0] ctr_wide_t;

    function automatic ctr_wide_t ctr_weak_nt(input int bits);
        return ctr_wide_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_wide_t sat_inc(input ctr_wide_t v, input int bits);
        ctr_wide_t max_v;
        max_v = ctr_wide_t'((1 << bits) - 1);
        return (v == max_v) ? v : v + ctr_wide_t'(1);
    endfunction

    function automatic ctr_wide_t sat_dec(input ctr_wide_t v);
        return (v == '0) ? v : v - ctr_wide_t'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, branch resolution and statistics signals between the core and the predictor.
interface branch_predictor_if #(
    parameter int XLEN    = 64,
    parameter int PHT_IDX = 6
) ();
    logic               fetch_valid;
    logic [XLEN-1:0]    fetch_pc;
    logic               pred_hit;
    logic               pred_taken;
    logic [XLEN-1:0]    pred_target;
    logic [PHT_IDX-1:0] pred_ghr;
    logic               upd_valid;
    logic [XLEN-1:0]    upd_pc;
    logic [XLEN-1:0]    upd_target;
    logic               upd_taken;
    logic               upd_pred_taken;
    logic [PHT_IDX-1:0] upd_ghr;
    logic               mispredict;
    logic [XLEN-1:0]    redirect_pc;
    logic [31:0]        stat_branches;
    logic [31:0]        stat_mispredicts;

    modport master (
        output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_pred_taken, upd_ghr,
        input  pred_hit, pred_taken, pred_target, pred_ghr, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_target, upd_taken,
               upd_pred_taken, upd_ghr,
        output pred_hit, pred_taken, pred_target, pred_ghr, mispredict, redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/sat_counter_table.sv
// Pattern history table: saturating counters with a combinational read port and a
// registered read-modify-write update port.
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX      = 6,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX-1:0]      rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX-1:0]      wr_idx,
    input  logic                wr_taken
);
    localparam int N = 1 << IDX;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [N];
    logic [CTR_BITS-1:0] ctr_d [N];
    logic [CTR_BITS-1:0] wr_old;

    assign rd_ctr = ctr_q[rd_idx];
    assign wr_old = ctr_q[wr_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = wr_taken ? CTR_BITS'(sat_inc(ctr_wide_t'(wr_old), CTR_BITS))
                                     : CTR_BITS'(sat_dec(ctr_wide_t'(wr_old)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RST;
        end else begin
            ctr_q <= ctr_d;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus bimodal/gshare PHT, speculative
// global history with mispredict restore, and saturating event statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int BTB_IDX  = 4,
    parameter int TAG_BITS = 12,
    parameter int PHT_IDX  = 6,
    parameter int CTR_BITS = 2,
    parameter int GSHARE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int BTB_N  = 1 << BTB_IDX;
    localparam int TAG_LO = BTB_IDX;
    localparam int TAG_HI = BTB_IDX + TAG_BITS - 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
    } btb_entry_t;

    btb_entry_t          btb_q [BTB_N];
    btb_entry_t          btb_d [BTB_N];
    logic [PHT_IDX-1:0]  ghr_q, ghr_d;
    logic [31:0]         stat_branches_q, stat_branches_d;
    logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

    btb_entry_t          f_ent, u_ent;
    logic                f_hit, u_hit, f_taken, mispredict;
    logic [XLEN-1:0]     u_target;
    logic [PHT_IDX-1:0]  f_pht_idx, u_pht_idx;
    logic [CTR_BITS-1:0] f_ctr;
    logic                unused_pc_hi;

    assign f_ent    = btb_q[bp.fetch_pc[BTB_IDX-1:0]];
    assign f_hit    = f_ent.valid && (f_ent.tag == bp.fetch_pc[TAG_HI:TAG_LO]);
    assign u_ent    = btb_q[bp.upd_pc[BTB_IDX-1:0]];
    assign u_hit    = u_ent.valid && (u_ent.tag == bp.upd_pc[TAG_HI:TAG_LO]);
    assign u_target = u_hit ? u_ent.target : '0;
    assign unused_pc_hi = ^bp.fetch_pc[XLEN-1:TAG_HI+1];

    // Fetch indexes with the live speculative history, updates with the snapshot
    // carried down the pipe, so both touch the same counter for a given branch.
    assign f_pht_idx = (GSHARE != 0) ? (bp.fetch_pc[PHT_IDX-1:0] ^ ghr_q)
                                     : bp.fetch_pc[PHT_IDX-1:0];
    assign u_pht_idx = (GSHARE != 0) ? (bp.upd_pc[PHT_IDX-1:0] ^ bp.upd_ghr)
                                     : bp.upd_pc[PHT_IDX-1:0];

    sat_counter_table #(
        .IDX      (PHT_IDX),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .rst_n    (reset),
        .rd_idx   (f_pht_idx),
        .rd_ctr   (f_ctr),
        .wr_en    (bp.upd_valid),
        .wr_idx   (u_pht_idx),
        .wr_taken (bp.upd_taken)
    );

    assign f_taken        = f_hit && f_ctr[CTR_BITS-1];
    assign bp.pred_hit    = f_hit;
    assign bp.pred_taken  = f_taken;
    assign bp.pred_target = f_hit ? f_ent.target : '0;
    assign bp.pred_ghr    = ghr_q;

    assign mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && bp.upd_pred_taken && (bp.upd_target != u_target)));
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = !bp.upd_valid ? '0 :
                            bp.upd_taken  ? bp.upd_target : bp.upd_pc + XLEN'(1);
    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;

    always_comb begin
        btb_d              = btb_q;
        ghr_d              = ghr_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bp.upd_valid && bp.upd_taken) begin
            btb_d[bp.upd_pc[BTB_IDX-1:0]] = '{valid: 1'b1,
                                               tag: bp.upd_pc[TAG_HI:TAG_LO],
                                               target: bp.upd_target};
        end
        // A mispredict restore wins over a same-cycle speculative shift.
        if (GSHARE != 0) begin
            if (mispredict) begin
                ghr_d = {bp.upd_ghr[PHT_IDX-2:0], bp.upd_taken};
            end else if (bp.fetch_valid && f_hit) begin
                ghr_d = {ghr_q[PHT_IDX-2:0], f_taken};
            end
        end
        if (bp.upd_valid && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
            ghr_q              <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            btb_q              <= btb_d;
            ghr_q              <= ghr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal instance for BTB/PHT/stat behaviour, gshare instance for
// speculative history and mispredict restore.
module tb_branch_predictor;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    branch_predictor_if #(.XLEN(64), .PHT_IDX(6)) bp0 ();
    branch_predictor_if #(.XLEN(64), .PHT_IDX(6)) bp1 ();

    branch_predictor #(.GSHARE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp0)
    );

    branch_predictor #(.GSHARE(1)) dut_g (
        .clk   (clk),
        .reset (reset),
        .bp    (bp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic up0(input logic [63:0] pc, input logic [63:0] tgt,
                       input logic tk, input logic ptk);
        bp0.upd_valid      = 1'b1;
        bp0.upd_pc         = pc;
        bp0.upd_target     = tgt;
        bp0.upd_taken      = tk;
        bp0.upd_pred_taken = ptk;
        bp0.upd_ghr        = 6'd0;
    endtask

    task automatic up1(input logic [63:0] pc, input logic [63:0] tgt,
                       input logic tk, input logic ptk, input logic [5:0] ghr);
        bp1.upd_valid      = 1'b1;
        bp1.upd_pc         = pc;
        bp1.upd_target     = tgt;
        bp1.upd_taken      = tk;
        bp1.upd_pred_taken = ptk;
        bp1.upd_ghr        = ghr;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bp0.fetch_valid = 1'b0; bp0.fetch_pc = 64'd5;
        bp0.upd_valid = 1'b0; bp0.upd_pc = '0; bp0.upd_target = '0;
        bp0.upd_taken = 1'b0; bp0.upd_pred_taken = 1'b0; bp0.upd_ghr = '0;
        bp1.fetch_valid = 1'b0; bp1.fetch_pc = 64'd0;
        bp1.upd_valid = 1'b0; bp1.upd_pc = '0; bp1.upd_target = '0;
        bp1.upd_taken = 1'b0; bp1.upd_pred_taken = 1'b0; bp1.upd_ghr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_hit",      64'(bp0.pred_hit),         64'd0);
        chk("rst_taken",    64'(bp0.pred_taken),       64'd0);
        chk("rst_target",   64'(bp0.pred_target),      64'd0);
        chk("rst_ghr",      64'(bp0.pred_ghr),         64'd0);
        chk("rst_mp",       64'(bp0.mispredict),       64'd0);
        chk("rst_redirect", 64'(bp0.redirect_pc),      64'd0);
        chk("rst_st_br",    64'(bp0.stat_branches),    64'd0);
        chk("rst_st_mp",    64'(bp0.stat_mispredicts), 64'd0);

        // allocation; same-cycle lookup sees old contents
        @(negedge clk);
        bp0.fetch_pc = 64'd8; bp0.fetch_valid = 1'b1;
        up0(64'd8, 64'd3, 1'b1, 1'b0);
        #1;
        chk("alloc_mp",       64'(bp0.mispredict),  64'd1);
        chk("alloc_redirect", 64'(bp0.redirect_pc), 64'd3);
        chk("alloc_samecyc",  64'(bp0.pred_hit),    64'd0);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("alloc_hit",    64'(bp0.pred_hit),         64'd1);
        chk("alloc_taken",  64'(bp0.pred_taken),       64'd1);
        chk("alloc_target", 64'(bp0.pred_target),      64'd3);
        chk("alloc_st_br",  64'(bp0.stat_branches),    64'd1);
        chk("alloc_st_mp",  64'(bp0.stat_mispredicts), 64'd1);

        // saturate high, then walk down to the floor
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b1, 1'b1);
        #1;
        chk("tk_correct_mp",  64'(bp0.mispredict),  64'd0);
        chk("tk_correct_rdr", 64'(bp0.redirect_pc), 64'd3);
        repeat (3) @(negedge clk);
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b0, 1'b1);
        #1;
        chk("nt1_mp",       64'(bp0.mispredict),  64'd1);
        chk("nt1_redirect", 64'(bp0.redirect_pc), 64'd9);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("ctr2_taken", 64'(bp0.pred_taken),       64'd1);
        chk("ctr2_st_br", 64'(bp0.stat_branches),    64'd6);
        chk("ctr2_st_mp", 64'(bp0.stat_mispredicts), 64'd2);
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b0, 1'b1);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("ctr1_taken", 64'(bp0.pred_taken), 64'd0);
        chk("ctr1_hit",   64'(bp0.pred_hit),   64'd1);
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b0, 1'b0);
        #1;
        chk("nt_correct_mp",  64'(bp0.mispredict),  64'd0);
        chk("nt_correct_rdr", 64'(bp0.redirect_pc), 64'd9);
        repeat (4) @(negedge clk);
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b1, 1'b0);
        #1;
        chk("floor_tk_mp", 64'(bp0.mispredict), 64'd1);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("floor_taken", 64'(bp0.pred_taken), 64'd0);
        @(negedge clk);
        up0(64'd8, 64'd3, 1'b1, 1'b0);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("rise_taken", 64'(bp0.pred_taken),       64'd1);
        chk("rise_st_br", 64'(bp0.stat_branches),    64'd14);
        chk("rise_st_mp", 64'(bp0.stat_mispredicts), 64'd5);

        // not-taken miss must not allocate
        @(negedge clk);
        bp0.fetch_pc = 64'd2;
        up0(64'd2, 64'd3, 1'b0, 1'b0);
        #1;
        chk("noalloc_mp",  64'(bp0.mispredict),  64'd0);
        chk("noalloc_rdr", 64'(bp0.redirect_pc), 64'd3);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("noalloc_hit", 64'(bp0.pred_hit), 64'd0);

        // stale target with correct direction
        @(negedge clk);
        bp0.fetch_pc = 64'd8;
        up0(64'd8, 64'd7, 1'b1, 1'b1);
        #1;
        chk("stale_mp",  64'(bp0.mispredict),  64'd1);
        chk("stale_rdr", 64'(bp0.redirect_pc), 64'd7);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("stale_target", 64'(bp0.pred_target), 64'd7);

        // aliasing: pc 24 shares BTB index 8 with a different tag
        @(negedge clk);
        up0(64'd24, 64'd40, 1'b1, 1'b0);
        #1;
        chk("alias_mp",  64'(bp0.mispredict),  64'd1);
        chk("alias_rdr", 64'(bp0.redirect_pc), 64'd40);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("alias_old_hit", 64'(bp0.pred_hit), 64'd0);
        bp0.fetch_pc = 64'd24;
        #1;
        chk("alias_new_hit",    64'(bp0.pred_hit),         64'd1);
        chk("alias_new_target", 64'(bp0.pred_target),      64'd40);
        chk("alias_new_taken",  64'(bp0.pred_taken),       64'd1);
        chk("bimodal_ghr",      64'(bp0.pred_ghr),         64'd0);
        chk("alias_st_br",      64'(bp0.stat_branches),    64'd17);
        chk("alias_st_mp",      64'(bp0.stat_mispredicts), 64'd7);

        // mispredict counter saturation
        @(negedge clk);
        force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_mispredicts_q;
        up0(64'd2, 64'd5, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("sat_first", 64'(bp0.stat_mispredicts), 64'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        bp0.upd_valid = 1'b0;
        #1;
        chk("sat_hold",  64'(bp0.stat_mispredicts), 64'hFFFF_FFFF);
        chk("sat_st_br", 64'(bp0.stat_branches),    64'd20);

        // asynchronous reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_st_br", 64'(bp0.stat_branches),    64'd0);
        chk("arst_st_mp", 64'(bp0.stat_mispredicts), 64'd0);
        chk("arst_hit",   64'(bp0.pred_hit),         64'd0);
        @(negedge clk);
        reset = 1'b1;
        bp0.fetch_valid = 1'b0;

        // gshare history: restore, shifts, restore overriding a fetch shift
        @(negedge clk);
        bp1.fetch_pc = 64'd8;
        up1(64'd8, 64'd3, 1'b1, 1'b0, 6'b000010);
        #1;
        chk("g_alloc_mp", 64'(bp1.mispredict), 64'd1);
        @(negedge clk);
        up1(64'd8, 64'd3, 1'b1, 1'b1, 6'b000101);
        #1;
        chk("g_ghr_restored", 64'(bp1.pred_ghr),   64'd5);
        chk("g_correct_mp",   64'(bp1.mispredict), 64'd0);
        @(negedge clk);
        bp1.upd_valid = 1'b0;
        bp1.fetch_valid = 1'b1;
        #1;
        chk("g_hit",        64'(bp1.pred_hit),   64'd1);
        chk("g_taken_hist", 64'(bp1.pred_taken), 64'd1);
        @(negedge clk);
        #1;
        chk("g_shift1",      64'(bp1.pred_ghr),   64'd11);
        chk("g_taken_other", 64'(bp1.pred_taken), 64'd0);
        @(negedge clk);
        up1(64'd8, 64'd3, 1'b0, 1'b1, 6'b000101);
        #1;
        chk("g_shift2",  64'(bp1.pred_ghr),    64'd22);
        chk("g_rec_mp",  64'(bp1.mispredict),  64'd1);
        chk("g_rec_rdr", 64'(bp1.redirect_pc), 64'd9);
        @(negedge clk);
        bp1.upd_valid = 1'b0;
        bp1.fetch_valid = 1'b0;
        #1;
        chk("g_recovered", 64'(bp1.pred_ghr), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
